// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-byte handshake between a client and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] err_code;
  modport master (output tx_data, tx_valid, input tx_ready, busy, tx_done, tx_error, err_code);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, tx_done, tx_error, err_code);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (request-to-send, frame, line-ack).
// Define PS2_HOST_TX_RETRY_EN to re-send a failed frame up to twice before reporting an error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  ps2_host_tx_if.slave tx,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
`ifdef PS2_HOST_TX_RETRY_EN
  ,
  output logic [1:0]  retry_cnt
`endif
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE} state_t;
  state_t          state, state_n;
  logic [1:0]      clk_sy, data_sy;
  logic            clk_f, clk_f_q;
  logic [FW-1:0]   flt_cnt;
  logic [7:0]      byte_q;
  logic            par_q;
  logic [2:0]      idx, idx_n;
  logic            drv, drv_n;
  logic [IW-1:0]   inh_cnt;
  logic [TW-1:0]   to_cnt;
  logic [1:0]      err_code, err_code_n;
  logic            fall, inh_last, in_to, timeout, nack, fail, last_try, accept, done, err;

  // The line idles high, so the synchronizers and filter start high to avoid a false fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sy  <= 2'b11;
      data_sy <= 2'b11;
      clk_f   <= 1'b1;
      clk_f_q <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_sy  <= {clk_sy[0], ps2_clk_in};
      data_sy <= {data_sy[0], ps2_data_in};
      clk_f_q <= clk_f;
      if (clk_sy[1] == clk_f) flt_cnt <= '0;
      else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f   <= clk_sy[1];
        flt_cnt <= '0;
      end else flt_cnt <= flt_cnt + 1'b1;
    end
  end

  assign fall     = clk_f_q & ~clk_f;
  assign accept   = (state == IDLE) && tx.tx_valid;
  assign inh_last = (state == INHIBIT) && (inh_cnt == IW'(INHIBIT_CYCLES - 1));
  assign in_to    = state inside {START, DATA, PARITY, STOP, ACK, WAIT_IDLE};
  assign timeout  = in_to && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign nack     = (state == ACK) && fall && data_sy[1];
  assign fail     = timeout | nack;

`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0] rtry;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rtry <= '0;
    else if (accept) rtry <= '0;
    else if (fail && !last_try) rtry <= rtry + 2'd1;
  end
  assign last_try  = (rtry == 2'd2);
  assign retry_cnt = rtry;
`else
  assign last_try = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      byte_q   <= '0;
      par_q    <= 1'b0;
      idx      <= '0;
      drv      <= 1'b0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      err_code <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      drv      <= drv_n;
      err_code <= err_code_n;
      inh_cnt  <= (state == INHIBIT && !inh_last) ? inh_cnt + 1'b1 : '0;
      to_cnt   <= (in_to && state_n != IDLE && state_n != INHIBIT) ? to_cnt + 1'b1 : '0;
      if (accept) begin
        byte_q <= tx.tx_data;
        par_q  <= ~^tx.tx_data;
      end
    end
  end

  // Each device falling edge moves the next bit onto the line; the device samples it on the rise.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    drv_n      = drv;
    err_code_n = accept ? 2'b00 : err_code;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE:      state_n = tx.tx_valid ? INHIBIT : IDLE;
      INHIBIT:   state_n = inh_last ? START : INHIBIT;
      START:     if (fall) begin
                   drv_n   = ~byte_q[0];
                   idx_n   = 3'd1;
                   state_n = DATA;
                 end
      DATA:      if (fall) begin
                   drv_n   = ~byte_q[idx];
                   idx_n   = idx + 3'd1;
                   state_n = (idx == 3'd7) ? PARITY : DATA;
                 end
      PARITY:    if (fall) begin
                   drv_n   = ~par_q;
                   state_n = STOP;
                 end
      STOP:      state_n = fall ? ACK : STOP;
      ACK:       state_n = fall ? WAIT_IDLE : ACK;
      WAIT_IDLE: if (clk_sy[1] && data_sy[1]) begin
                   done    = 1'b1;
                   state_n = IDLE;
                 end
      default:   state_n = IDLE;
    endcase
    // A timeout on the same cycle as a fall or an idle bus wins over both.
    if (fail) begin
      done       = 1'b0;
      err        = last_try;
      err_code_n = last_try ? (timeout ? 2'b01 : 2'b10) : err_code;
      state_n    = last_try ? IDLE : INHIBIT;
    end
  end

  assign ps2_clk_oe  = (state == INHIBIT);
  assign ps2_data_oe = inh_last || (state == START) || (drv && state inside {DATA, PARITY, STOP});
  assign tx.tx_ready = (state == IDLE);
  assign tx.busy     = (state != IDLE);
  assign tx.tx_done  = done;
  assign tx.tx_error = err;
  assign tx.err_code = err_code;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed frame vectors against a behavioural PS/2 device on an open-drain bus.
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TO  = 3000;
  localparam int H   = 40;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATT = 3;
`else
  localparam int ATT = 1;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic ps2_clk_oe, ps2_data_oe, ps2_clk_line, ps2_data_line;
  always #5 clk = ~clk;
  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if ifc();
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0] retry_cnt;
`endif

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tx(ifc.slave),
    .ps2_clk_in(ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
`ifdef PS2_HOST_TX_RETRY_EN
    ,
    .retry_cnt(retry_cnt)
`endif
  );

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: inhibit run lengths, START entry cycle, and pulse bookkeeping.
  int cyc = 0, inh_run = 0, last_inh = 0, inh_phases = 0, start_cyc = 0, err_cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic prev_oe = 1'b0, err_pend = 1'b0, post_ready = 1'b0;
  logic [1:0] post_oe = 2'b11, post_code = 2'b00;
  always @(negedge clk) begin
    cyc++;
    if (ps2_clk_oe) inh_run++;
    else if (prev_oe) begin
      last_inh = inh_run;
      inh_phases++;
      inh_run = 0;
      start_cyc = cyc;
    end
    prev_oe = ps2_clk_oe;
    if (ifc.tx_done) done_cnt++;
    if (ifc.tx_done && ifc.tx_error) both_cnt++;
    if (ifc.tx_error) begin
      err_cnt++;
      err_cyc = cyc;
      err_pend = 1'b1;
    end else if (err_pend) begin
      post_ready = ifc.tx_ready;
      post_oe = {ps2_clk_oe, ps2_data_oe};
      post_code = ifc.err_code;
      err_pend = 1'b0;
    end
  end

  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #1 ifc.tx_data = d;
    ifc.tx_valid = 1'b1;
    @(posedge clk);
    #1 ifc.tx_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (ps2_clk_oe) begin ok = 1'b1; break; end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
        @(negedge clk);
        if (!ps2_clk_oe) begin ok = 1'b1; break; end
      end
    end
    #1;
    if (!ok) chk("start_wait_bound", 0, 1);
  endtask

  // Frame as seen on the wire: [0] start, [8:1] data LSB first, [9] parity, [10] stop.
  task automatic dev_frame(input bit ack, input int stop_after, input int glitch_after,
                           output logic [10:0] bits);
    bit ok;
    bits = '0;
    wait_start(ok);
    if (!ok) return;
    bits[0] = ps2_data_line;
    for (int k = 1; k <= 10; k++) begin
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      bits[k] = ps2_data_line;
      if (k == stop_after) return;
      dev_clk_low = 1'b0;
      if (k == glitch_after) begin
        repeat (H / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
      end
    end
    repeat (H) @(negedge clk);
    dev_data_low = ack;
    repeat (4) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (H) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [10:0] frame;
  } vec_t;
  vec_t v[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [10:0] bits;
    int d0, e0, p0;
    bit seen;
    v[0] = '{8'hED, 11'b1_1_11101101_0};
    v[1] = '{8'h00, 11'b1_1_00000000_0};
    v[2] = '{8'hFF, 11'b1_1_11111111_0};
    v[3] = '{8'h01, 11'b1_0_00000001_0};
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ifc.tx_ready, ifc.busy, ifc.tx_done, ifc.tx_error, ifc.err_code,
                          ps2_clk_oe, ps2_data_oe}, 8'b1000_0000);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send(v[i].d);
      dev_frame(1'b1, 0, 0, bits);
      repeat (60) @(negedge clk);
      chk($sformatf("inhibit_len_%0h", v[i].d), last_inh, INH);
      chk($sformatf("frame_%0h", v[i].d), bits, v[i].frame);
      chk($sformatf("done_%0h", v[i].d), done_cnt - d0, 1);
      chk($sformatf("no_err_%0h", v[i].d), err_cnt - e0, 0);
      chk($sformatf("err_code_%0h", v[i].d), ifc.err_code, 2'b00);
    end

    // NACK: device leaves data high on the 11th clock of every attempt.
    e0 = err_cnt; d0 = done_cnt; p0 = inh_phases;
    send(8'hFF);
    for (int a = 0; a < ATT; a++) dev_frame(1'b0, 0, 0, bits);
    repeat (60) @(negedge clk);
    chk("nack_err_pulse", err_cnt - e0, 1);
    chk("nack_no_done", done_cnt - d0, 0);
    chk("nack_code", post_code, 2'b10);
    chk("nack_ready_next", post_ready, 1'b1);
    chk("nack_released", post_oe, 2'b00);
    chk("nack_attempts", inh_phases - p0, ATT);
`ifdef PS2_HOST_TX_RETRY_EN
    chk("nack_retry_cnt", retry_cnt, 2'd2);
`endif

    // Timeout: the device never clocks.
    e0 = err_cnt; p0 = inh_phases;
    send(8'h12);
    seen = 1'b0;
    for (int i = 0; i < ATT * (TO + INH + 50) + 100; i++) begin
      @(negedge clk);
      if (ifc.tx_error) begin seen = 1'b1; break; end
    end
    #1;
    chk("timeout_seen", seen, 1'b1);
    chk("timeout_latency", err_cyc - start_cyc + 1, TO);
    repeat (5) @(negedge clk);
    chk("timeout_code", ifc.err_code, 2'b01);
    chk("timeout_released", post_oe, 2'b00);
    chk("timeout_err_pulse", err_cnt - e0, 1);
    chk("timeout_attempts", inh_phases - p0, ATT);
`ifdef PS2_HOST_TX_RETRY_EN
    chk("timeout_retry_cnt", retry_cnt, 2'd2);
`endif

    // Reset after bit 3 (0xA5 bit3 = 0, so data is being pulled low).
    send(8'hA5);
    dev_frame(1'b1, 4, 0, bits);
    chk("mid_frame_data_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    #2 reset_n = 1'b0;
    #1 chk("async_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {ifc.tx_ready, ifc.busy, ifc.err_code}, 4'b1000);
    d0 = done_cnt;
    send(8'hF4);
    dev_frame(1'b1, 0, 0, bits);
    repeat (60) @(negedge clk);
    chk("frame_f4_after_reset", bits, 11'b1_0_11110100_0);
    chk("done_f4", done_cnt - d0, 1);

    // Short clock glitch during DATA, plus a request while busy that must be dropped.
    d0 = done_cnt; p0 = inh_phases;
    send(8'h3C);
    @(posedge clk);
    #1 ifc.tx_data = 8'hAA;
    ifc.tx_valid = 1'b1;
    @(posedge clk);
    #1 ifc.tx_valid = 1'b0;
    dev_frame(1'b1, 0, 3, bits);
    repeat (300) @(negedge clk);
    chk("glitch_frame_3c", bits, 11'b1_1_00111100_0);
    chk("glitch_done", done_cnt - d0, 1);
    chk("busy_valid_ignored", inh_phases - p0, 1);
    chk("done_error_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same open-drain ps2_clk/ps2_data lines the receive path listens on.
- Performs the request-to-send sequence, shifts out data, odd parity and stop bit on device-generated clocks, then checks the device's line-ack.
- busy is routed to the receive path so it ignores bus activity during a host transmit.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles ps2_clk is held low for request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: max clk cycles from clock release to ack sample (20 ms at 100 MHz).
- FILTER_LEN, 8: consecutive identical synchronized samples required to accept a new ps2_clk level.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in any state except IDLE
- tx_done  out  1  one-cycle pulse, frame acked by device
- tx_error  out  1  one-cycle pulse, frame failed
- err_code  out  2  held from last tx_error: 01 timeout, 10 NACK; cleared on next accept
- ps2_clk_in  in  1  raw PS/2 clock line
- ps2_data_in  in  1  raw PS/2 data line
- ps2_clk_oe  out  1  1 = drive ps2_clk low, 0 = release
- ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; tx_ready=1; busy=0.
  - tx_done=0, tx_error=0, err_code=00.
  - ps2_clk_oe=0, ps2_data_oe=0. Lines are released immediately, even mid-frame.
- Input conditioning:
  - Both PS/2 inputs pass through a 2-FF synchronizer.
  - ps2_clk is then filtered: the level changes only after FILTER_LEN equal samples.
  - fall = filtered level goes 1->0 (one-cycle strobe).
- Accept: in IDLE with tx_valid=1, latch tx_data and parity = ~^tx_data (odd). Go to INHIBIT next cycle. tx_valid outside IDLE is ignored, not queued.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - ps2_data_oe goes to 1 on the last inhibit cycle (start bit).
  - Then go to START.
- START:
  - ps2_clk_oe=0, ps2_data_oe=1.
  - The timeout counter starts here and is cleared only on exit to ACK-resolution or IDLE.
  - Bit index = 0. On each fall, go to DATA.
- DATA: on each fall, drive bit[idx] with ps2_data_oe = ~bit. After bit7 is driven (8th fall), go to PARITY.
- PARITY: on the next fall, drive parity (ps2_data_oe = ~parity). Go to STOP.
- STOP: on the next fall (10th), ps2_data_oe=0 (stop bit = released high). Go to ACK.
- ACK: on the 11th fall, sample synchronized ps2_data_in.
  - 0: ack; go to WAIT_IDLE.
  - 1: NACK; tx_error=1, err_code=10, go to IDLE.
- WAIT_IDLE: when synchronized clk and data are both high, pulse tx_done and go to IDLE. This state is also covered by the timeout.
- Timeout: if TIMEOUT_CYCLES elapse in START..WAIT_IDLE:
  - Release both lines (oe=0).
  - Pulse tx_error with err_code=01.
  - Go to IDLE.
- Simultaneity: a timeout expiring on the same cycle as a fall takes priority (error path).
- tx_done and tx_error are never asserted together.
- tx_ready returns to 1 the cycle after tx_done/tx_error, so back-to-back sends are allowed.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN
- When defined:
  - On NACK or timeout, the frame is re-sent from INHIBIT with the latched byte, up to 2 retries (retry counter 2 bits, cleared on accept).
  - tx_error and err_code are reported only after the final attempt fails.
  - busy stays high across retries.
  - An extra output retry_cnt[1:0] reports the retries used on the last frame.
- When undefined: no retry logic, no retry_cnt port; the first failure reports tx_error.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz that acks:
  - ps2_clk held low 10000 cycles, start 0.
  - Bits observed LSB first 1,0,1,1,0,1,1,1; parity 1; stop 1.
  - tx_done pulses once, err_code=00.
- Sends 0x00, 0xFF and 0x01 -> parity observed 1, 1 and 0 respectively; all tx_done.
- Device model leaves data high on the 11th clock -> tx_error pulse, err_code=10, lines released, tx_ready=1 next cycle.
- Device never clocks -> tx_error with err_code=01 exactly TIMEOUT_CYCLES after START entry; with PS2_HOST_TX_RETRY_EN, 3 INHIBIT phases first, then retry_cnt=2.
- Assert reset_n=0 after bit 3 -> ps2_clk_oe and ps2_data_oe drop to 0 asynchronously; after release, state IDLE and a new 0xF4 sends cleanly.
- Glitch (ps2_clk low for 3 cycles, FILTER_LEN=8) during DATA -> no bit advance; tx_valid pulsed while busy -> ignored, only the first byte is sent.
